// File: rtl/adder63_share_arbiter_pkg.sv
// Shared widths and result-register state encoding for the shared-adder arbiter.
package adder63_share_arbiter_pkg;

   localparam int unsigned A_W         = 63;
   localparam int unsigned B_W         = 40;
   localparam int unsigned S_W         = 64;
   localparam int unsigned B_EXT_W     = A_W - B_W;
   localparam int unsigned NUM_REQ_DEF = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } res_state_e;

endpackage

// File: rtl/adder63_share_arbiter_rr_grant.sv
// Round-robin priority encoder: first requester at or above ptr, wrapping.
module adder63_share_arbiter_rr_grant #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [ID_W-1:0]    idx_c
);

   // Scan NUM_REQ slots starting at ptr; ptr is always below NUM_REQ.
   always_comb begin
      logic        found;
      int unsigned j;
      grant_c = '0;
      idx_c   = '0;
      found   = 1'b0;
      j       = 0;
      if (en) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
               grant_c[j] = 1'b1;
               idx_c      = ID_W'(j);
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/unsignedRippleCarryAdder63bit.sv
// 63-bit unsigned ripple-carry adder; sum[63] is the carry-out.
module unsignedRippleCarryAdder63bit (
   input  logic [62:0] a,
   input  logic [62:0] b,
   output logic [63:0] sum
);

   localparam int unsigned W = 63;

   // Bit-serial carry chain, LSB first.
   always_comb begin
      logic carry;
      carry = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      sum[W] = carry;
   end

endmodule

// File: rtl/adder63_share_arbiter.sv
// Time-shares one 63-bit adder among NUM_REQ requesters behind a one-entry result register.
module adder63_share_arbiter
   import adder63_share_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [S_W-1:0]         res_sum,
   output logic [ID_W-1:0]        res_id
);

   res_state_e          state_q, state_d;
   logic [ID_W-1:0]     ptr_q;
   logic [ID_W-1:0]     ptr_d_c;
   logic                can_accept_c;
   logic                xfer_c;
   logic [NUM_REQ-1:0]  grant_c;
   logic [ID_W-1:0]     gnt_idx_c;
   logic [A_W-1:0]      a_sel_c;
   logic [B_W-1:0]      b_sel_c;
   logic [A_W-1:0]      b_ext_c;
   logic [S_W-1:0]      sum_c;

   assign res_valid    = (state_q == ST_FULL);
   assign can_accept_c = !res_valid || res_ready;
   assign req_ready    = grant_c;
   assign xfer_c       = |grant_c;
   assign ptr_d_c      = ID_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
   assign b_ext_c      = {{B_EXT_W{1'b0}}, b_sel_c};

   // Grant is suppressed in reset so nothing is offered while rst_n is low.
   adder63_share_arbiter_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_grant (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (can_accept_c && rst_n),
      .grant_c (grant_c),
      .idx_c   (gnt_idx_c)
   );

   // One-hot AND-OR operand mux driven by the grant vector.
   always_comb begin
      a_sel_c = '0;
      b_sel_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         a_sel_c = a_sel_c | (req_a[i*A_W +: A_W] & {A_W{grant_c[i]}});
         b_sel_c = b_sel_c | (req_b[i*B_W +: B_W] & {B_W{grant_c[i]}});
      end
   end

   unsignedRippleCarryAdder63bit u_adder (
      .a   (a_sel_c),
      .b   (b_ext_c),
      .sum (sum_c)
   );

   // Result register occupancy: fill on transfer, empty on drain without refill.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (xfer_c) state_d = ST_FULL;
         ST_FULL:  if (!xfer_c && res_ready) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   // Result payload and round-robin pointer advance only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sum <= '0;
         res_id  <= '0;
         ptr_q   <= '0;
      end else if (xfer_c) begin
         res_sum <= sum_c;
         res_id  <= gnt_idx_c;
         ptr_q   <= ptr_d_c;
      end
   end

endmodule
